// File: rtl/pipe_reg_em_elastic.sv
// E->M pipeline register as a 2-entry valid/ready skid buffer with synchronous bubble flush.
// Optional macro EM_EXC_FREEZE_EN: a sticky freeze on accepting a non-AOK beat, cleared by bubble/reset.
module pipe_reg_em_elastic #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned REG_W     = 4,
  parameter int unsigned STAT_W    = 4,
  parameter int unsigned ICODE_W   = 4,
  parameter int unsigned STAT_AOK  = 1,
  parameter int unsigned ICODE_NOP = 1,
  parameter int unsigned REG_NONE  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               e_valid,
  output logic               e_ready,
  input  logic [STAT_W-1:0]  e_stat,
  input  logic [ICODE_W-1:0] e_icode,
  input  logic               e_cnd,
  input  logic [DATA_W-1:0]  e_valE,
  input  logic [DATA_W-1:0]  e_valA,
  input  logic [REG_W-1:0]   e_dstE,
  input  logic [REG_W-1:0]   e_dstM,
  input  logic               bubble,
  output logic               M_valid,
  input  logic               M_ready,
  output logic [STAT_W-1:0]  M_stat,
  output logic [ICODE_W-1:0] M_icode,
  output logic               M_cnd,
  output logic [DATA_W-1:0]  M_valE,
  output logic [DATA_W-1:0]  M_valA,
  output logic [REG_W-1:0]   M_dstE,
  output logic [REG_W-1:0]   M_dstM,
  output logic [1:0]         occ
);

  localparam int unsigned BEAT_W = STAT_W + ICODE_W + 1 + 2 * DATA_W + 2 * REG_W;
  localparam logic [STAT_W-1:0]  AOK  = STAT_W'(STAT_AOK);
  localparam logic [ICODE_W-1:0] NOP  = ICODE_W'(ICODE_NOP);
  localparam logic [REG_W-1:0]   NONE = REG_W'(REG_NONE);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   main_q, main_d;
  logic [BEAT_W-1:0]   skid_q, skid_d;
  logic [BEAT_W-1:0]   in_beat, empty_beat, out_beat;
  logic                take_in, take_out;

  assign in_beat    = {e_stat, e_icode, e_cnd, e_valE, e_valA, e_dstE, e_dstM};
  assign empty_beat = {AOK, NOP, 1'b0, DATA_W'(0), DATA_W'(0), NONE, NONE};

  // Output fields are muxed on state so EMPTY values appear immediately on reset or flush.
  assign out_beat = (state_q == S_EMPTY) ? empty_beat : main_q;
  assign {M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM} = out_beat;

  assign M_valid  = (state_q != S_EMPTY);
  assign take_in  = e_valid & e_ready;
  assign take_out = M_valid & M_ready;

  always_comb begin
    occ = 2'd0;
    case (state_q)
      S_ONE:   occ = 2'd1;
      S_TWO:   occ = 2'd2;
      default: occ = 2'd0;
    endcase
  end

`ifdef EM_EXC_FREEZE_EN
  logic frz_q, frz_d;

  assign e_ready = (state_q != S_TWO) && !frz_q;

  always_comb begin
    frz_d = frz_q;
    if (bubble)
      frz_d = 1'b0;
    else if (take_in && (e_stat != AOK))
      frz_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frz_q <= 1'b0;
    else        frz_q <= frz_d;
  end
`else
  assign e_ready = (state_q != S_TWO);
`endif

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bubble) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (take_in) begin
            state_d = S_ONE;
            main_d  = in_beat;
          end
        end
        S_ONE: begin
          if (take_in && take_out) begin
            main_d = in_beat;
          end else if (take_in) begin
            state_d = S_TWO;
            skid_d  = in_beat;
          end else if (take_out) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (take_out) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: doc/pipe_reg_em_elastic.md
Name: pipe_reg_em_elastic

Overview:
Parametrised elastic pipeline register between the Execute and Memory stages of the Y86-64 pipeline. Replaces the free-running E->M latch with a 2-entry valid/ready skid buffer. Adds synchronous bubble/flush insertion and configurable data/register-ID widths. Downstream back-pressure is absorbed without a combinational ready path from the M side to the E side.

Parameters:
DATA_W, 64, width of valE/valA
REG_W, 4, width of dstE/dstM register IDs
STAT_W, 4, width of stat field
ICODE_W, 4, width of icode field
STAT_AOK, 1, stat encoding for normal operation, also the bubble stat
ICODE_NOP, 1, icode inserted on bubble
REG_NONE, 15, register ID meaning "no destination", inserted on bubble

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
e_valid  in  1  E stage presents a beat
e_ready  out  1  block can accept a beat; registered
e_stat  in  STAT_W  status
e_icode  in  ICODE_W  instruction code
e_cnd  in  1  condition flag
e_valE  in  DATA_W  ALU result
e_valA  in  DATA_W  operand A
e_dstE  in  REG_W  E destination
e_dstM  in  REG_W  M destination
bubble  in  1  synchronous flush, discards all buffered and incoming beats
M_valid  out  1  output beat valid
M_ready  in  1  M stage accepts output beat
M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM  out  widths as inputs  output beat fields
occ  out  2  entries held, 0..2

Behaviour:
- Storage: main entry drives M_* outputs; skid entry holds one overflow beat.
- Transfer in: e_valid & e_ready at the edge. Transfer out: M_valid & M_ready at the edge.
- States: EMPTY (occ=0, M_valid=0, e_ready=1); ONE (occ=1, M_valid=1, e_ready=1); TWO (occ=2, M_valid=1, e_ready=0).
- EMPTY: in -> ONE, beat loaded into main.
- ONE:
  - in only -> TWO, beat into skid.
  - out only -> EMPTY.
  - in and out together -> ONE, new beat into main.
- TWO:
  - out -> ONE, skid moves to main.
  - no in is possible since e_ready=0.
- Latency: a beat accepted at edge N is visible on M_* after edge N, with M_valid=1 in cycle N+1.
- Ordering: strict FIFO; no beat is duplicated or dropped except by bubble.
- Outputs in EMPTY: M_stat=STAT_AOK, M_icode=ICODE_NOP, M_cnd=0, M_valE=0, M_valA=0, M_dstE=REG_NONE, M_dstM=REG_NONE.
- Output stability: M_* stay stable while M_valid=1 and M_ready=0.
- bubble=1 at an edge has highest priority:
  - state goes to EMPTY, outputs take the EMPTY values, e_ready=1.
  - Any same-cycle input beat is discarded, and any same-cycle output handshake is still counted as consumed by downstream.
- Reset (rst_n low, any time, including mid-transfer): immediately EMPTY, outputs take the EMPTY values, e_ready=1, occ=0. The first accept is possible at the first edge after rst_n rises.
- Fields are copied bit-exact; no arithmetic. Widths are fixed by the parameters; no truncation.
- e_ready depends only on registered state, never on M_ready in the same cycle.

Optional Feature:
Macro EM_EXC_FREEZE_EN.
- Defined:
  - When a beat with e_stat != STAT_AOK is accepted, a sticky freeze flag sets and e_ready is forced to 0.
  - Buffered beats, including the exception beat, still drain normally.
  - The flag clears only on bubble or reset. This stops younger instructions entering M after an exception.
- Undefined: stat is carried opaquely, there is no freeze logic, and e_ready follows state only.

Test Plan:
1. Reset then stream: rst_n low 3 cycles, M_ready=1, 4 beats with valE=0x10,0x20,0x30,0x40 -> M_valid asserted one cycle after each accept, same order, occ<=1, e_ready always 1.
2. Back-pressure: M_ready=0, send valE=0xA then 0xB -> occ=2, e_ready=0, M_valE=0xA held. Raise M_ready -> 0xA, then 0xB, then EMPTY with M_icode=1, M_dstE=0xF.
3. Simultaneous in/out in ONE: main=0x5, M_ready=1, send 0x6 same cycle -> next cycle M_valE=0x6, occ=1.
4. Bubble in TWO with e_valid=1 (valE=0x99) -> next cycle occ=0, M_valid=0, M_icode=ICODE_NOP, 0x99 never appears at output.
5. Async reset mid-transfer: rst_n low between edges while occ=2 -> outputs go to EMPTY values before the next edge, e_ready=1.
6. With EM_EXC_FREEZE_EN: accept beat with e_stat=2 (HLT) -> e_ready=0 from the next cycle. The HLT beat drains to M. e_ready stays 0 until a bubble pulse, then returns to 1.
